// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 timing constants, lock-state encoding, the event
//   bundle passed from the sync counter to the decoder top, and small
//   counter helpers.
package vga_timing_pkg;

   // Nominal 640x480@60 timing, in pixels (horizontal) and lines (vertical)
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL     = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
   localparam int V_TOTAL     = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
   localparam int H_VIS_START = H_SYNC_DEF + H_BP_DEF;                            // 144
   localparam int V_VIS_START = V_SYNC_DEF + V_BP_DEF;                            // 35

   // Both line and frame counters are 10 bits and saturate at all-ones
   localparam int               CNT_W   = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

   // Per-tick events from the sync counter; every field is already
   // qualified by pixEn, so a field is high for at most one clk per tick.
   typedef struct packed {
      logic frame_start;
      logic line_err;
      logic frame_err;
   } sync_evt_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter
//   Sync edge detection plus the horizontal / vertical position counters.
//   Produces the counter values the current pixEn tick loads (so the top can
//   register a pixel with its coordinates in the same clk), and the
//   frame-start / line-error / frame-error events of that tick.
// Ports:
//   clk, reset            100 MHz clock, async active-low reset
//   pixEn                 pixel strobe; nothing changes on other clks
//   hSync, vSync          raw sync pins
//   hcount_nxt/vcount_nxt position of the pixel sampled on this tick
//   evt                   frame_start, line_err, frame_err for this tick
module vga_sync_counter
   import vga_timing_pkg::*;
#(
   parameter int H_TOT           = H_TOTAL,
   parameter int V_TOT           = V_TOTAL,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixEn,
   input  logic             hSync,
   input  logic             vSync,
   output logic [CNT_W-1:0] hcount_nxt,
   output logic [CNT_W-1:0] vcount_nxt,
   output sync_evt_t        evt
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

   logic             hs, vs;          // sync asserted, polarity removed
   logic             hs_q;            // hs at the previous tick
   logic             vs_at_edge;      // vs at the previous hSync leading edge
   logic             edge_raw, fs_raw;
   logic [CNT_W-1:0] hcount, vcount;

   assign hs = (SYNC_ACTIVE_LOW != 0) ? ~hSync : hSync;
   assign vs = (SYNC_ACTIVE_LOW != 0) ? ~vSync : vSync;

   always_comb begin
      edge_raw = hs & ~hs_q;
      // Frame start is seen on an hSync leading edge: vSync is asserted now
      // but was not at the previous leading edge.
      fs_raw   = edge_raw & vs & ~vs_at_edge;

      hcount_nxt = edge_raw ? '0 : sat_inc(hcount);
      if (fs_raw)
         vcount_nxt = '0;
      else if (edge_raw)
         vcount_nxt = sat_inc(vcount);
      else
         vcount_nxt = vcount;

      evt.frame_start = pixEn & fs_raw;
      // An edge must land exactly on the last pixel of the line. Without an
      // edge the error fires only on the step from H_TOT-1 to H_TOT, so a
      // missing sync costs a single error per line.
      evt.line_err    = pixEn & (edge_raw ? (hcount != H_LAST) : (hcount == H_LAST));
      evt.frame_err   = pixEn & fs_raw & (vcount != V_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs_q       <= 1'b0;
         vs_at_edge <= 1'b0;
         hcount     <= '0;
         vcount     <= '0;
      end else if (pixEn) begin
         hs_q   <= hs;
         hcount <= hcount_nxt;
         vcount <= vcount_nxt;
         if (edge_raw)
            vs_at_edge <= vs;
      end
   end

endmodule

// File: rtl/vga_frame_decoder.sv
// vga_frame_decoder
//   Receive side of the VGA path. Recovers pixel coordinates and frame
//   boundaries from a sampled VGA stream, validates line/frame lengths with a
//   SEARCH -> TRACK -> LOCKED state machine, counts timing errors and produces
//   a 16-bit additive checksum of every complete locked frame.
// Ports:
//   clk, reset                100 MHz clock, async active-low reset
//   pixEn                     1-in-4 pixel strobe qualifying all sampling
//   hSync, vSync              sync inputs (polarity set by SYNC_ACTIVE_LOW)
//   VGA_R, VGA_G, VGA_B       4-bit colour inputs
//   pixValid                  one-clk pulse per visible pixel while LOCKED
//   pixX, pixY, pixColor      coordinates and {R,G,B} of that pixel
//   frameStart                one-clk pulse per recognised frame start
//   locked                    timing validated
//   errCount                  saturating timing-error count
//   frameChecksum             checksum of the last complete locked frame
//   checksumValid             frameChecksum is current
module vga_frame_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE        = H_ACTIVE_DEF,
   parameter int H_FP            = H_FP_DEF,
   parameter int H_SYNC          = H_SYNC_DEF,
   parameter int H_BP            = H_BP_DEF,
   parameter int V_ACTIVE        = V_ACTIVE_DEF,
   parameter int V_FP            = V_FP_DEF,
   parameter int V_SYNC          = V_SYNC_DEF,
   parameter int V_BP            = V_BP_DEF,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixEn,
   input  logic        hSync,
   input  logic        vSync,
   input  logic [3:0]  VGA_R,
   input  logic [3:0]  VGA_G,
   input  logic [3:0]  VGA_B,
   output logic        pixValid,
   output logic [9:0]  pixX,
   output logic [8:0]  pixY,
   output logic [11:0] pixColor,
   output logic        frameStart,
   output logic        locked,
   output logic [7:0]  errCount,
   output logic [15:0] frameChecksum,
   output logic        checksumValid
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_VIS_LO = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] H_VIS_HI = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_VIS_LO = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] V_VIS_HI = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

   logic [CNT_W-1:0] hcount_nxt, vcount_nxt;
   sync_evt_t        evt;

   lock_state_e state, state_nxt;
   logic        err_any;      // timing error seen this tick
   logic        err_inc;      // error that costs the lock
   logic        cs_latch;     // publish the accumulator this tick
   logic        visible;      // sampled pixel lies in the visible window
   logic        pix_fire;     // visible pixel while LOCKED
   logic [11:0] color;
   logic [15:0] acc;

   vga_sync_counter #(
      .H_TOT           (H_TOT),
      .V_TOT           (V_TOT),
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_sync (
      .clk        (clk),
      .reset      (reset),
      .pixEn      (pixEn),
      .hSync      (hSync),
      .vSync      (vSync),
      .hcount_nxt (hcount_nxt),
      .vcount_nxt (vcount_nxt),
      .evt        (evt)
   );

   assign color    = {VGA_R, VGA_G, VGA_B};
   assign visible  = in_window(hcount_nxt, H_VIS_LO, H_VIS_HI) &
                     in_window(vcount_nxt, V_VIS_LO, V_VIS_HI);
   // Gated by the state before this tick; lock changes only happen on
   // frame starts and errors, which never fall on a visible pixel.
   assign pix_fire = pixEn & visible & (state == LOCKED);
   assign err_any  = evt.line_err | evt.frame_err;

   // Lock state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= SEARCH;
      else
         state <= state_nxt;
   end

   // Lock next-state. SEARCH takes the first frame start it sees whatever
   // the timing around it, since the counters are not yet aligned to the
   // stream. From TRACK/LOCKED an error wins over a simultaneous frame
   // start, which also suppresses the checksum latch.
   always_comb begin
      state_nxt = state;
      err_inc   = 1'b0;
      cs_latch  = 1'b0;
      unique case (state)
         SEARCH: begin
            if (evt.frame_start)
               state_nxt = TRACK;
         end
         TRACK: begin
            if (err_any) begin
               state_nxt = SEARCH;
               err_inc   = 1'b1;
            end else if (evt.frame_start) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (err_any) begin
               state_nxt = SEARCH;
               err_inc   = 1'b1;
            end else if (evt.frame_start) begin
               cs_latch  = 1'b1;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // Pixel and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixValid   <= 1'b0;
         pixX       <= '0;
         pixY       <= '0;
         pixColor   <= '0;
         frameStart <= 1'b0;
         locked     <= 1'b0;
         errCount   <= '0;
      end else begin
         pixValid   <= pix_fire;
         frameStart <= evt.frame_start;
         locked     <= (state_nxt == LOCKED);
         if (pix_fire) begin
            pixX     <= 10'(hcount_nxt - H_VIS_LO);
            pixY     <= 9'(vcount_nxt - V_VIS_LO);
            pixColor <= color;
         end
         if (err_inc && (errCount != 8'hFF))
            errCount <= errCount + 8'd1;
      end
   end

   // Frame checksum. The accumulator runs in every state; it is only
   // published from LOCKED, where the whole finished frame was locked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc           <= '0;
         frameChecksum <= '0;
         checksumValid <= 1'b0;
      end else begin
         if (pixEn) begin
            if (evt.frame_start)
               acc <= '0;
            else if (visible)
               acc <= acc + {4'b0000, color};
         end
         if (cs_latch) begin
            frameChecksum <= acc;
            checksumValid <= 1'b1;
         end else if (state_nxt != LOCKED) begin
            checksumValid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/vga_frame_decoder.md
# vga_frame_decoder

Receive-side counterpart of the VGA output path: watches a VGA stream (hSync, vSync, 12-bit RGB) in the 100 MHz domain and recovers pixel coordinates, frame boundaries and a per-frame checksum. It sits on the board-level VGA pins or in a loopback bench. Its main uses are self-checking the display path (sprite and background rendering, screen timing) and capturing frames. A lock state machine validates line and frame lengths against 640x480@60 timing and counts timing errors.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths, in lines
- SYNC_ACTIVE_LOW, 1, sync pulses are low while asserted

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- pixEn  in  1  one-cycle strobe, 1 in 4 clk (25 MHz pixel rate); all sampling is qualified by it
- hSync, vSync  in  1 each  sync inputs, same clock domain
- VGA_R, VGA_G, VGA_B  in  4 each  colour inputs
- pixValid  out  1  the pixel outputs carry a visible pixel
- pixX  out  10  visible column, 0..639
- pixY  out  9  visible row, 0..479
- pixColor  out  12  {R,G,B} of that pixel
- frameStart  out  1  one-clk pulse at each recognised frame start
- locked  out  1  timing validated
- errCount  out  8  timing-error count, saturates at 255
- frameChecksum  out  16  checksum of the last complete locked frame
- checksumValid  out  1  frameChecksum holds a valid value

## Operation
- Sync edge detection: register hSync and vSync on pixEn. A leading edge is the transition to the asserted level.
- hcount (10 b):
  - Cleared to 0 on the pixEn tick that sees the hSync leading edge; otherwise increments on each pixEn.
  - Saturates at 1023.
- vcount (10 b):
  - Increments on each hSync leading edge.
  - Frame start = the hSync leading edge where vSync is asserted and was deasserted at the previous hSync leading edge. At frame start vcount is cleared to 0.
- Visible region:
  - Horizontal: hcount in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1], i.e. 144..783.
  - Vertical: vcount in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1], i.e. 35..514.
  - pixX = hcount-144; pixY = vcount-35.
- Line error: either of
  - an hSync leading edge where hcount ≠ H_TOTAL-1 (799);
  - hcount reaching H_TOTAL (800) with no edge. This error is raised once per line.
- Frame error: frame start where the previous frame's line count ≠ V_TOTAL (525).
- Lock FSM:
  - SEARCH: leaves on a frame start, to TRACK.
  - TRACK: any error goes to SEARCH and increments errCount. A frame start with zero errors in the frame goes to LOCKED.
  - LOCKED: any error goes to SEARCH and increments errCount.
- Outputs by state:
  - locked = (state == LOCKED).
  - pixValid is asserted only in LOCKED and only in the visible region.
  - frameStart pulses on every recognised frame start, in any state.
- Checksum:
  - Accumulator (16 b) sums the zero-extended pixColor of every visible pixel, modulo 2^16.
  - Cleared at each frame start.
  - At a frame start in LOCKED, the accumulator is latched to frameChecksum and checksumValid is set.
  - Leaving LOCKED clears checksumValid. frameChecksum keeps its value.
- Simultaneous line error and frame start: the error takes priority, the state goes to SEARCH, and the checksum is not latched.

## Timing
- All outputs are registered.
- Pixel outputs and frameStart appear 1 clk after the pixEn tick that sampled the inputs. They hold until the next pixEn update.
- pixValid is a one-clk pulse per visible pixel.
- locked rises 1 clk after the pixEn tick of the second consecutive good frame start. This is the first frame start after entering TRACK.
- errCount increments 1 clk after the detecting tick.
- Reset (asserted at any time, including mid-frame):
  - state = SEARCH; counters = 0; all outputs 0; errCount = 0; checksumValid = 0.
  - After release, decoding resumes from SEARCH.
- Ticks with pixEn low change no state.

## Structure
- Shared package vga_timing_pkg:
  - 640x480 timing constants, H_TOTAL = 800, V_TOTAL = 525.
  - Visible-region bounds, 144 and 35.
  - Lock-state enum {SEARCH, TRACK, LOCKED}.
- One sub-module, vga_sync_counter: edge detection plus the hcount/vcount counters, frame-start detection and line-error detection.
- Lock FSM, checksum and output registers live in the top module.

## Test plan
- Reset: drive reset low mid-stream -> all outputs 0, locked=0, errCount=0. Release -> locked=1 after two frame starts.
- Coordinate mapping: send a nominal frame with colour = {x[3:0], y[3:0], 4'h5} -> every pixValid carries pixX=x, pixY=y and the matching colour; exactly 307200 pixValid pulses per frame.
- Checksum:
  - All-white frame (12'hFFF), locked -> frameChecksum=16'h5000, checksumValid=1.
  - All-black frame -> frameChecksum=16'h0000.
- Short line: one line of 799 pixels while LOCKED -> locked drops, errCount 0→1, checksumValid=0. Relocks after two further good frame starts.
- Missing hSync: hSync held deasserted for 900 ticks -> exactly one error (errCount +1) and locked=0.
- Bad frame length: 524-line frame during TRACK -> no lock, errCount +1. Next two good frames -> locked=1.
